// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative 32-bit shifter moving STEP bit positions per cycle, valid/ready on both sides.
// Optional macro SHIFT_SEQ_PERF_EN adds a free-running count of SHIFT cycles on perf_cycles.
module shift_sequencer #(
   parameter int STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  Shiftop,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Result,
   output logic [31:0] perf_cycles
);
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

   localparam logic [4:0] STEP_AMT = 5'(STEP);
   localparam logic [1:0] OP_SLL   = 2'b00;
   localparam logic [1:0] OP_ILL   = 2'b01;
   localparam logic [1:0] OP_SRL   = 2'b10;
   localparam logic [1:0] OP_SRA   = 2'b11;

   state_e      state_q, state_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  rem_q, rem_d;
   logic [1:0]  op_q, op_d;
   logic [4:0]  step_s;
   logic [4:0]  rem_next_s;
   logic [31:0] shifted_s;
   logic        accept_s;
   logic        unused_b_s;

   assign unused_b_s = ^B[31:5];
   assign accept_s   = in_valid & in_ready;
   assign Result     = data_q;

   // One shift step: the last step is shortened so the total never overshoots B[4:0].
   always_comb begin
      step_s     = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
      rem_next_s = rem_q - step_s;
      case (op_q)
         OP_SLL:  shifted_s = data_q << step_s;
         OP_SRL:  shifted_s = data_q >> step_s;
         OP_SRA:  shifted_s = 32'($signed(data_q) >>> step_s);
         default: shifted_s = data_q;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath load; DONE with out_ready behaves like IDLE so a new op lands with no bubble.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      op_d    = op_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept_s) begin
               op_d  = Shiftop;
               rem_d = B[4:0];
               if (Shiftop == OP_ILL) begin
                  data_d  = 32'd0;
                  state_d = DONE;
               end else if (B[4:0] == 5'd0) begin
                  data_d  = A;
                  state_d = DONE;
               end else begin
                  data_d  = A;
                  state_d = SHIFT;
               end
            end else if ((state_q == DONE) && out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = state_q;
            end
         end
         SHIFT: begin
            data_d = shifted_s;
            rem_d  = rem_next_s;
            if (rem_next_s == 5'd0) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake outputs
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         SHIFT: begin
            in_ready = 1'b0;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= 32'd0;
         rem_q  <= 5'd0;
         op_q   <= 2'b00;
      end else begin
         data_q <= data_d;
         rem_q  <= rem_d;
         op_q   <= op_d;
      end
   end

`ifdef SHIFT_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   assign perf_d      = (state_q == SHIFT) ? (perf_q + 32'd1) : perf_q;
   assign perf_cycles = perf_q;

   // SHIFT-cycle counter, wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= 32'd0;
      end else begin
         perf_q <= perf_d;
      end
   end
`else
   assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (STEP=1 and STEP=4 instances).
module tb_shift_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a_s, b_s, result, perf;
   logic [1:0]  op_s;
   logic        in4_valid, in4_ready, out4_valid, out4_ready;
   logic [31:0] a4_s, b4_s, result4, perf4;
   logic [1:0]  op4_s;

   int checks = 0;
   int errors = 0;
   int exp_perf = 0;

`ifdef SHIFT_SEQ_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   shift_sequencer #(.STEP(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a_s), .B(b_s), .Shiftop(op_s), .out_valid(out_valid),
      .out_ready(out_ready), .Result(result), .perf_cycles(perf)
   );

   shift_sequencer #(.STEP(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in4_valid), .in_ready(in4_ready),
      .A(a4_s), .B(b4_s), .Shiftop(op4_s), .out_valid(out4_valid),
      .out_ready(out4_ready), .Result(result4), .perf_cycles(perf4)
   );

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      a_s = a; b_s = b; op_s = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || perf !== 32'd0) begin
         errors++;
         $display("FAIL reset got rdy=%b vld=%b res=%h perf=%h exp 1 0 0 0", in_ready, out_valid, result, perf);
      end
      checks++;
      if (in4_ready !== 1'b1 || out4_valid !== 1'b0 || result4 !== 32'd0) begin
         errors++;
         $display("FAIL reset4 got rdy=%b vld=%b res=%h exp 1 0 0", in4_ready, out4_valid, result4);
      end
      #21 rst_n = 1'b1;
   endtask

   task automatic test_sll();
      int lat;
      start_op(32'h0000_0001, 32'd4, 2'b00);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL sll_busy got %b exp 0", in_ready); end
      wait_done(lat);
      exp_perf += 4;
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL sll_latency got %0d exp 4", lat); end
      checks++;
      if (result !== 32'h0000_0010) begin errors++; $display("FAIL sll_result got %h exp 00000010", result); end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL sll_idle got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_sra_srl();
      int lat;
      start_op(32'h8000_0000, 32'd31, 2'b11);
      wait_done(lat);
      exp_perf += 31;
      checks++;
      if (lat !== 31) begin errors++; $display("FAIL sra_latency got %0d exp 31", lat); end
      checks++;
      if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra_result got %h exp ffffffff", result); end
      @(posedge clk); #1;
      start_op(32'h8000_0000, 32'h0000_0023, 2'b10);
      wait_done(lat);
      exp_perf += 3;
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL srl_latency got %0d exp 3", lat); end
      checks++;
      if (result !== 32'h1000_0000) begin errors++; $display("FAIL srl_result got %h exp 10000000", result); end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_illegal();
      int lat;
      start_op(32'hDEAD_BEEF, 32'd0, 2'b00);
      wait_done(lat);
      checks++;
      if (lat !== 0 || result !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL zero_amt got lat=%0d res=%h exp 0 deadbeef", lat, result);
      end
      @(posedge clk); #1;
      start_op(32'hDEAD_BEEF, 32'd5, 2'b01);
      wait_done(lat);
      checks++;
      if (lat !== 0 || result !== 32'd0) begin
         errors++; $display("FAIL illegal_op got lat=%0d res=%h exp 0 00000000", lat, result);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b0;
      start_op(32'h0000_000F, 32'd2, 2'b00);
      wait_done(lat);
      exp_perf += 2;
      checks++;
      if (lat !== 2 || result !== 32'h0000_003C) begin
         errors++; $display("FAIL bp_first got lat=%0d res=%h exp 2 0000003c", lat, result);
      end
      a_s = 32'hFFFF_FFFF; b_s = 32'd7; op_s = 2'b10; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (result !== 32'h0000_003C || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc %0d got res=%h vld=%b rdy=%b exp 0000003c 1 0", i, result, out_valid, in_ready);
         end
      end
      a_s = 32'h0000_0001; b_s = 32'd1; op_s = 2'b00; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_accept got vld=%b rdy=%b exp 0 0", out_valid, in_ready);
      end
      wait_done(lat);
      exp_perf += 1;
      checks++;
      if (lat !== 1 || result !== 32'h0000_0002) begin
         errors++; $display("FAIL b2b_result got lat=%0d res=%h exp 1 00000002", lat, result);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int lat;
      bit seen;
      checks++;
      if (perf !== (PERF_ON ? 32'(exp_perf) : 32'd0)) begin
         errors++; $display("FAIL perf_total got %0d exp %0d", perf, PERF_ON ? exp_perf : 0);
      end
      start_op(32'h0000_0001, 32'd20, 2'b00);
      repeat (5) begin @(posedge clk); #1; end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || perf !== 32'd0) begin
         errors++;
         $display("FAIL async_reset got rdy=%b vld=%b res=%h perf=%h exp 1 0 0 0", in_ready, out_valid, result, perf);
      end
      #20 rst_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL discarded_op got vld_seen=%b exp 0", seen); end
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      start_op(32'h0000_0004, 32'd1, 2'b10);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL first_edge_accept got rdy=%b exp 0", in_ready); end
      wait_done(lat);
      checks++;
      if (lat !== 1 || result !== 32'h0000_0002) begin
         errors++; $display("FAIL post_reset_op got lat=%0d res=%h exp 1 00000002", lat, result);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_step4();
      int lat;
      a4_s = 32'h0000_0001; b4_s = 32'd10; op4_s = 2'b00; in4_valid = 1'b1;
      @(posedge clk); #1;
      in4_valid = 1'b0;
      lat = 0;
      while (!out4_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL step4_latency got %0d exp 3", lat); end
      checks++;
      if (result4 !== 32'h0000_0400) begin errors++; $display("FAIL step4_result got %h exp 00000400", result4); end
      checks++;
      if (perf4 !== (PERF_ON ? 32'd3 : 32'd0)) begin
         errors++; $display("FAIL step4_perf got %0d exp %0d", perf4, PERF_ON ? 3 : 0);
      end
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b1; a_s = 32'd0; b_s = 32'd0; op_s = 2'b00;
      in4_valid = 1'b0; out4_ready = 1'b1; a4_s = 32'd0; b4_s = 32'd0; op4_s = 2'b00;
      test_reset();
      test_sll();
      test_sra_srl();
      test_zero_illegal();
      test_back_to_back();
      test_reset_mid();
      test_step4();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
